// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multicycle MIPS core: instruction field
// encodings used by branch resolution, the resolver FSM state type and
// a decode helper that classifies an instruction as a branch/jump kind.
package mips_cpu_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    // SPECIAL function codes (instr[5:0])
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    // REGIMM selectors (instr[20:16])
    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    // Return-address register used by the implicit-link forms
    localparam logic [4:0] LINK_RA    = 5'd31;

    // Redirect sequencing states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SLOT     = 2'd1,
        REDIRECT = 2'd2
    } branch_state_t;

    // Every control-transfer flavour the resolver understands
    typedef enum logic [3:0] {
        BR_NONE   = 4'd0,
        BR_J      = 4'd1,
        BR_JAL    = 4'd2,
        BR_JR     = 4'd3,
        BR_JALR   = 4'd4,
        BR_BEQ    = 4'd5,
        BR_BNE    = 4'd6,
        BR_BLEZ   = 4'd7,
        BR_BGTZ   = 4'd8,
        BR_BLTZ   = 4'd9,
        BR_BGEZ   = 4'd10,
        BR_BLTZAL = 4'd11,
        BR_BGEZAL = 4'd12
    } branch_kind_t;

    // Classify an instruction; BLEZ/BGTZ are only branches when rt is zero
    function automatic branch_kind_t decode_branch(
        input logic [5:0] opcode,
        input logic [5:0] fn,
        input logic [4:0] rt_field
    );
        branch_kind_t kind;
        kind = BR_NONE;
        case (opcode)
            OP_SPECIAL: begin
                if (fn == FN_JR) begin
                    kind = BR_JR;
                end else if (fn == FN_JALR) begin
                    kind = BR_JALR;
                end
            end
            OP_REGIMM: begin
                case (rt_field)
                    RT_BLTZ:   kind = BR_BLTZ;
                    RT_BGEZ:   kind = BR_BGEZ;
                    RT_BLTZAL: kind = BR_BLTZAL;
                    RT_BGEZAL: kind = BR_BGEZAL;
                    default:   kind = BR_NONE;
                endcase
            end
            OP_J:    kind = BR_J;
            OP_JAL:  kind = BR_JAL;
            OP_BEQ:  kind = BR_BEQ;
            OP_BNE:  kind = BR_BNE;
            OP_BLEZ: kind = (rt_field == 5'd0) ? BR_BLEZ : BR_NONE;
            OP_BGTZ: kind = (rt_field == 5'd0) ? BR_BGTZ : BR_NONE;
            default: kind = BR_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/mips_cpu_branch_cond.sv
// Combinational half of the branch resolver: decodes the instruction,
// evaluates the branch condition, selects the target address and works
// out the link destination and link value.
module mips_cpu_branch_cond
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [5:0]        opcode,
    input  logic [5:0]        fn,
    input  logic [4:0]        rt_field,
    input  logic [4:0]        rd_field,
    input  logic [15:0]       imm16,
    input  logic [25:0]       instr_index,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [ADDR_W-1:0] pc_plus4,
    output logic              is_branch,
    output logic              taken,
    output logic [ADDR_W-1:0] target,
    output logic              misaligned,
    output logic              link_en,
    output logic [4:0]        link_dest,
    output logic [DATA_W-1:0] link_value
);

    branch_kind_t        kind;
    logic                rs_neg;
    logic                rs_zero;
    logic                rs_eq_rt;
    logic signed [17:0]  offset;
    logic [ADDR_W-1:0]   branch_tgt;
    logic [ADDR_W-1:0]   jump_tgt;
    logic [ADDR_W-1:0]   reg_tgt;

    assign kind     = decode_branch(opcode, fn, rt_field);
    assign rs_neg   = rs_data[DATA_W-1];
    assign rs_zero  = (rs_data == '0);
    assign rs_eq_rt = (rs_data == rt_data);

    // The signed cast sign-extends the word offset to the PC width
    assign offset     = {imm16, 2'b00};
    assign branch_tgt = pc_plus4 + ADDR_W'(offset);
    assign reg_tgt    = rs_data[ADDR_W-1:0];

    // The link value is the address after the delay slot
    assign link_value = DATA_W'(pc_plus4 + ADDR_W'(4));

    // Region jump keeps the upper PC bits above the 28-bit index window
    always_comb begin
        jump_tgt       = pc_plus4;
        jump_tgt[27:0] = {instr_index, 2'b00};
    end

    // Condition evaluation and target/link selection per branch kind
    always_comb begin
        is_branch = 1'b1;
        taken     = 1'b0;
        target    = branch_tgt;
        link_en   = 1'b0;
        link_dest = LINK_RA;
        case (kind)
            BR_NONE: begin
                is_branch = 1'b0;
            end
            BR_J: begin
                taken  = 1'b1;
                target = jump_tgt;
            end
            BR_JAL: begin
                taken   = 1'b1;
                target  = jump_tgt;
                link_en = 1'b1;
            end
            BR_JR: begin
                taken  = 1'b1;
                target = reg_tgt;
            end
            BR_JALR: begin
                taken     = 1'b1;
                target    = reg_tgt;
                link_en   = 1'b1;
                link_dest = rd_field;
            end
            BR_BEQ:  taken = rs_eq_rt;
            BR_BNE:  taken = !rs_eq_rt;
            BR_BLEZ: taken = rs_neg || rs_zero;
            BR_BGTZ: taken = !rs_neg && !rs_zero;
            BR_BLTZ: taken = rs_neg;
            BR_BGEZ: taken = !rs_neg;
            BR_BLTZAL: begin
                taken   = rs_neg;
                link_en = 1'b1;
            end
            BR_BGEZAL: begin
                taken   = !rs_neg;
                link_en = 1'b1;
            end
            default: begin
                is_branch = 1'b0;
            end
        endcase
    end

    assign misaligned = taken && (target[1:0] != 2'b00);

endmodule

// File: rtl/mips_cpu_branch_resolver.sv
// Registered branch/jump resolution unit. Accepts a resolved branch from
// EXEC, issues the link write, counts branches, and sequences the PC
// redirect around the delay-slot fetch.
module mips_cpu_branch_resolver
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DELAY_SLOTS = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              resolve,
    input  logic [5:0]        opcode,
    input  logic [5:0]        fn,
    input  logic [4:0]        rt_field,
    input  logic [4:0]        rd_field,
    input  logic [15:0]       imm16,
    input  logic [25:0]       instr_index,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic              fetch_ack,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              link_we,
    output logic [4:0]        link_reg,
    output logic [DATA_W-1:0] link_data,
    output logic              busy,
    output logic              addr_err,
    output logic              nested_err,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  taken_count
);

    branch_state_t     state;
    branch_state_t     next_state;

    logic              is_branch;
    logic              taken;
    logic              misaligned;
    logic [ADDR_W-1:0] target;
    logic              link_en;
    logic [4:0]        link_dest;
    logic [DATA_W-1:0] link_value;

    logic              accept;
    logic              launch;
    logic              nested;

    mips_cpu_branch_cond #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cond (
        .opcode      (opcode),
        .fn          (fn),
        .rt_field    (rt_field),
        .rd_field    (rd_field),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .pc_plus4    (pc_plus4),
        .is_branch   (is_branch),
        .taken       (taken),
        .target      (target),
        .misaligned  (misaligned),
        .link_en     (link_en),
        .link_dest   (link_dest),
        .link_value  (link_value)
    );

    // A misaligned taken target is accepted and counted but never redirects
    assign accept = resolve && (state == IDLE) && is_branch;
    assign launch = accept && taken && !misaligned;
    assign nested = resolve && (state != IDLE);

    assign redirect_valid = (state == REDIRECT);
    assign busy           = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Redirect sequencing; fetch_ack outside SLOT/REDIRECT has no effect
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    next_state = (DELAY_SLOTS != 0) ? SLOT : REDIRECT;
                end
            end
            SLOT: begin
                if (fetch_ack) begin
                    next_state = REDIRECT;
                end
            end
            REDIRECT: begin
                if (fetch_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Link write, error pulses and the held redirect target
    always_ff @(posedge clk) begin
        if (reset) begin
            link_we     <= 1'b0;
            link_reg    <= '0;
            link_data   <= '0;
            addr_err    <= 1'b0;
            nested_err  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            link_we    <= accept && link_en && (link_dest != 5'd0);
            addr_err   <= accept && misaligned;
            nested_err <= nested;
            if (accept && link_en) begin
                link_reg  <= link_dest;
                link_data <= link_value;
            end
            if (launch) begin
                redirect_pc <= target;
            end
        end
    end

    // Saturating statistics; misaligned taken branches still count as taken
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (accept) begin
            if (branch_count != '1) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (taken && (taken_count != '1)) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_branch_resolver.sv
// Bench for mips_cpu_branch_resolver: a default instance checked through
// a scoreboard of expected link writes, redirects and error pulses, plus
// a DELAY_SLOTS=0 / CNT_W=4 instance for immediate redirect and saturation.
module tb_mips_cpu_branch_resolver;

    logic        clk = 1'b0;
    logic        reset;
    logic        alt_reset;
    logic        resolve;
    logic        fetch_ack;
    logic [5:0]  opcode;
    logic [5:0]  fn;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] pc_plus4;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        link_we;
    logic [4:0]  link_reg;
    logic [31:0] link_data;
    logic        busy;
    logic        addr_err;
    logic        nested_err;
    logic [15:0] branch_count;
    logic [15:0] taken_count;

    logic        a_redirect_valid;
    logic [31:0] a_redirect_pc;
    logic        a_link_we;
    logic [4:0]  a_link_reg;
    logic [31:0] a_link_data;
    logic        a_busy;
    logic        a_addr_err;
    logic        a_nested_err;
    logic [3:0]  a_branch_count;
    logic [3:0]  a_taken_count;

    typedef struct packed {
        logic [4:0]  lreg;
        logic [31:0] ldata;
    } link_exp_t;

    link_exp_t   link_q[$];
    logic [31:0] redir_q[$];
    int          exp_addr_err = 0;
    int          exp_nested   = 0;
    link_exp_t   mon_link;
    logic [31:0] mon_redir;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_cpu_branch_resolver u_dut (
        .clk            (clk),
        .reset          (reset),
        .resolve        (resolve),
        .opcode         (opcode),
        .fn             (fn),
        .rt_field       (rt_field),
        .rd_field       (rd_field),
        .imm16          (imm16),
        .instr_index    (instr_index),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .pc_plus4       (pc_plus4),
        .fetch_ack      (fetch_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .link_we        (link_we),
        .link_reg       (link_reg),
        .link_data      (link_data),
        .busy           (busy),
        .addr_err       (addr_err),
        .nested_err     (nested_err),
        .branch_count   (branch_count),
        .taken_count    (taken_count)
    );

    mips_cpu_branch_resolver #(
        .DELAY_SLOTS (0),
        .CNT_W       (4)
    ) u_alt (
        .clk            (clk),
        .reset          (alt_reset),
        .resolve        (resolve),
        .opcode         (opcode),
        .fn             (fn),
        .rt_field       (rt_field),
        .rd_field       (rd_field),
        .imm16          (imm16),
        .instr_index    (instr_index),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .pc_plus4       (pc_plus4),
        .fetch_ack      (fetch_ack),
        .redirect_valid (a_redirect_valid),
        .redirect_pc    (a_redirect_pc),
        .link_we        (a_link_we),
        .link_reg       (a_link_reg),
        .link_data      (a_link_data),
        .busy           (a_busy),
        .addr_err       (a_addr_err),
        .nested_err     (a_nested_err),
        .branch_count   (a_branch_count),
        .taken_count    (a_taken_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Present one instruction with resolve high for a single cycle
    task automatic applyStimulus(
        input logic [5:0]  op,
        input logic [5:0]  f,
        input logic [4:0]  rt_sel,
        input logic [4:0]  rd_sel,
        input logic [15:0] imm,
        input logic [25:0] idx,
        input logic [31:0] rs_val,
        input logic [31:0] rt_val,
        input logic [31:0] pc4,
        input logic        ack
    );
        opcode      = op;
        fn          = f;
        rt_field    = rt_sel;
        rd_field    = rd_sel;
        imm16       = imm;
        instr_index = idx;
        rs_data     = rs_val;
        rt_data     = rt_val;
        pc_plus4    = pc4;
        resolve     = 1'b1;
        fetch_ack   = ack;
        step();
        resolve     = 1'b0;
        fetch_ack   = 1'b0;
        opcode      = 6'h00;
        fn          = 6'h00;
    endtask

    task automatic fetchAck();
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
    endtask

    // Monitor: every output event of the default instance consumes one expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (link_we) begin
                checks++;
                if (link_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL link_unexpected actual reg=%0d data=%h expected no link write", link_reg, link_data);
                end else begin
                    mon_link = link_q.pop_front();
                    if (link_reg !== mon_link.lreg || link_data !== mon_link.ldata) begin
                        errors++;
                        $display("[TB] FAIL link_write actual reg=%0d data=%h expected reg=%0d data=%h",
                                 link_reg, link_data, mon_link.lreg, mon_link.ldata);
                    end
                end
            end
            if (redirect_valid && fetch_ack) begin
                checks++;
                if (redir_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL redirect_unexpected actual=%h expected no redirect", redirect_pc);
                end else begin
                    mon_redir = redir_q.pop_front();
                    if (redirect_pc !== mon_redir) begin
                        errors++;
                        $display("[TB] FAIL redirect_pc actual=%h expected=%h", redirect_pc, mon_redir);
                    end
                end
            end
            if (addr_err) begin
                checks++;
                if (exp_addr_err == 0) begin
                    errors++;
                    $display("[TB] FAIL addr_err_unexpected actual=1 expected=0");
                end else begin
                    exp_addr_err--;
                end
            end
            if (nested_err) begin
                checks++;
                if (exp_nested == 0) begin
                    errors++;
                    $display("[TB] FAIL nested_err_unexpected actual=1 expected=0");
                end else begin
                    exp_nested--;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        alt_reset   = 1'b1;
        resolve     = 1'b0;
        fetch_ack   = 1'b0;
        opcode      = 6'h00;
        fn          = 6'h00;
        rt_field    = 5'd0;
        rd_field    = 5'd0;
        imm16       = 16'h0;
        instr_index = 26'h0;
        rs_data     = 32'h0;
        rt_data     = 32'h0;
        pc_plus4    = 32'h0;
        repeat (3) step();
        reset = 1'b0;
        step();

        checkOutput("reset_busy",         32'(busy),           32'd0);
        checkOutput("reset_redir_valid",  32'(redirect_valid), 32'd0);
        checkOutput("reset_redirect_pc",  redirect_pc,         32'd0);
        checkOutput("reset_link_data",    link_data,           32'd0);
        checkOutput("reset_branch_count", 32'(branch_count),   32'd0);
        checkOutput("reset_taken_count",  32'(taken_count),    32'd0);

        // BEQ taken: target 0x1000_0004 + 3*4
        redir_q.push_back(32'h1000_0010);
        applyStimulus(6'h04, 6'h00, 5'd0, 5'd0, 16'h0003, 26'h0, 32'd5, 32'd5, 32'h1000_0004, 1'b0);
        checkOutput("beq_busy",        32'(busy),           32'd1);
        checkOutput("beq_slot_no_redir", 32'(redirect_valid), 32'd0);
        fetchAck();
        checkOutput("beq_redir_valid", 32'(redirect_valid), 32'd1);
        fetchAck();
        checkOutput("beq_idle",        32'(busy),           32'd0);
        checkOutput("beq_branch_cnt",  32'(branch_count),   32'd1);
        checkOutput("beq_taken_cnt",   32'(taken_count),    32'd1);

        // BGEZAL with negative rs: not taken but still links
        link_q.push_back('{lreg: 5'd31, ldata: 32'h0040_0014});
        applyStimulus(6'h01, 6'h00, 5'h11, 5'd0, 16'h0010, 26'h0, 32'hFFFF_FFFF, 32'h0, 32'h0040_0010, 1'b0);
        checkOutput("bgezal_busy",       32'(busy),         32'd0);
        checkOutput("bgezal_branch_cnt", 32'(branch_count), 32'd2);
        checkOutput("bgezal_taken_cnt",  32'(taken_count),  32'd1);

        // JR to a misaligned address
        exp_addr_err++;
        applyStimulus(6'h00, 6'h08, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0040_0002, 32'h0, 32'h0000_0100, 1'b0);
        checkOutput("jr_misaligned_busy",  32'(busy),           32'd0);
        checkOutput("jr_misaligned_redir", 32'(redirect_valid), 32'd0);
        checkOutput("jr_taken_cnt",        32'(taken_count),    32'd2);

        // BNE taken backwards, then a J arriving during the delay slot
        redir_q.push_back(32'h0000_1FF8);
        applyStimulus(6'h05, 6'h00, 5'd0, 5'd0, 16'hFFFE, 26'h0, 32'd1, 32'd2, 32'h0000_2000, 1'b0);
        exp_nested++;
        applyStimulus(6'h02, 6'h00, 5'd0, 5'd0, 16'h0, 26'h0000123, 32'h0, 32'h0, 32'h0000_2004, 1'b0);
        checkOutput("nested_still_busy", 32'(busy),         32'd1);
        fetchAck();
        fetchAck();
        checkOutput("nested_branch_cnt", 32'(branch_count), 32'd4);
        checkOutput("nested_taken_cnt",  32'(taken_count),  32'd3);

        // JALR rd=5 links and redirects; JALR rd=0 redirects without a link write
        link_q.push_back('{lreg: 5'd5, ldata: 32'h0000_0504});
        redir_q.push_back(32'h0000_3000);
        applyStimulus(6'h00, 6'h09, 5'd0, 5'd5, 16'h0, 26'h0, 32'h0000_3000, 32'h0, 32'h0000_0500, 1'b0);
        fetchAck();
        fetchAck();
        redir_q.push_back(32'h0000_4000);
        applyStimulus(6'h00, 6'h09, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0000_4000, 32'h0, 32'h0000_0600, 1'b0);
        fetchAck();
        fetchAck();

        // Non-branches: LW, and BLEZ with a nonzero rt field
        applyStimulus(6'h23, 6'h00, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0, 32'h0, 32'h0000_0700, 1'b0);
        applyStimulus(6'h06, 6'h00, 5'd3, 5'd0, 16'h0004, 26'h0, 32'h0, 32'h0, 32'h0000_0800, 1'b0);
        checkOutput("nonbranch_busy",      32'(busy),         32'd0);
        checkOutput("nonbranch_branch_cnt", 32'(branch_count), 32'd6);

        // BGTZ with rs=0 is a branch but not taken
        applyStimulus(6'h07, 6'h00, 5'd0, 5'd0, 16'h0004, 26'h0, 32'h0, 32'h0, 32'h0000_0900, 1'b0);
        checkOutput("bgtz_branch_cnt", 32'(branch_count), 32'd7);
        checkOutput("bgtz_taken_cnt",  32'(taken_count),  32'd5);

        // J with fetch_ack in the same IDLE cycle: resolve wins
        redir_q.push_back(32'h0040_0000);
        applyStimulus(6'h02, 6'h00, 5'd0, 5'd0, 16'h0, 26'h0100000, 32'h0, 32'h0, 32'h0040_0008, 1'b1);
        checkOutput("j_ack_busy",  32'(busy),           32'd1);
        checkOutput("j_ack_redir", 32'(redirect_valid), 32'd0);
        fetchAck();
        fetchAck();

        // JAL keeps the upper region bits of pc_plus4
        link_q.push_back('{lreg: 5'd31, ldata: 32'h2000_0104});
        redir_q.push_back(32'h2000_0100);
        applyStimulus(6'h03, 6'h00, 5'd0, 5'd0, 16'h0, 26'h0000040, 32'h0, 32'h0, 32'h2000_0100, 1'b0);
        fetchAck();
        fetchAck();
        checkOutput("jal_branch_cnt", 32'(branch_count), 32'd9);
        checkOutput("jal_taken_cnt",  32'(taken_count),  32'd7);

        // Reset in the middle of a pending redirect discards it
        applyStimulus(6'h04, 6'h00, 5'd0, 5'd0, 16'h0004, 26'h0, 32'h0, 32'h0, 32'h0000_0100, 1'b0);
        checkOutput("midreset_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("midreset_busy",         32'(busy),         32'd0);
        checkOutput("midreset_redirect_pc",  redirect_pc,       32'd0);
        checkOutput("midreset_branch_count", 32'(branch_count), 32'd0);
        fetchAck();
        checkOutput("midreset_no_redir", 32'(redirect_valid), 32'd0);

        // Second instance: immediate redirect and counter saturation
        reset     = 1'b1;
        alt_reset = 1'b0;
        step();
        applyStimulus(6'h02, 6'h00, 5'd0, 5'd0, 16'h0, 26'h0100000, 32'h0, 32'h0, 32'h0040_0008, 1'b0);
        checkOutput("ds0_redir_valid", 32'(a_redirect_valid), 32'd1);
        checkOutput("ds0_redirect_pc", a_redirect_pc,         32'h0040_0000);
        checkOutput("ds0_busy",        32'(a_busy),           32'd1);
        alt_reset = 1'b1;
        step();
        alt_reset = 1'b0;
        checkOutput("ds0_reset_redir_valid", 32'(a_redirect_valid), 32'd0);
        checkOutput("ds0_reset_busy",        32'(a_busy),           32'd0);
        checkOutput("ds0_reset_redirect_pc", a_redirect_pc,         32'd0);
        checkOutput("ds0_reset_taken_cnt",   32'(a_taken_count),    32'd0);
        step();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(6'h04, 6'h00, 5'd0, 5'd0, 16'h0001, 26'h0, 32'd7, 32'd7, 32'h0000_1000, 1'b0);
            fetchAck();
        end
        checkOutput("sat_branch_cnt", 32'(a_branch_count), 32'd15);
        checkOutput("sat_taken_cnt",  32'(a_taken_count),  32'd15);

        checkOutput("pending_links",     32'(link_q.size()),  32'd0);
        checkOutput("pending_redirects", 32'(redir_q.size()), 32'd0);
        checkOutput("pending_addr_err",  32'(exp_addr_err),   32'd0);
        checkOutput("pending_nested",    32'(exp_nested),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
